// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared opcodes, FSM state encoding and strobe-vector bit
// indices for the register-op sequencer (reg_op_sequencer / reg_seq_decode).
package reg_seq_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_CLR = 4'd1;
  localparam logic [OP_W-1:0] OP_LD  = 4'd2;
  localparam logic [OP_W-1:0] OP_INC = 4'd3;
  localparam logic [OP_W-1:0] OP_DEC = 4'd4;
  localparam logic [OP_W-1:0] OP_SHR = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_ROR = 4'd7;
  localparam logic [OP_W-1:0] OP_ROL = 4'd8;
  localparam logic [OP_W-1:0] OP_ALU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Bit positions of the register strobes inside the strobe vector
  localparam int unsigned STB_CL  = 0;
  localparam int unsigned STB_LD  = 1;
  localparam int unsigned STB_INC = 2;
  localparam int unsigned STB_DEC = 3;
  localparam int unsigned STB_SR  = 4;
  localparam int unsigned STB_SL  = 5;
  localparam int unsigned STB_W   = 6;

  // Opcodes that repeat their strobe N times
  function automatic logic is_repeat(input logic [OP_W-1:0] op);
    return (op >= OP_INC) && (op <= OP_ROL);
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op > OP_ALU;
  endfunction

endpackage

// File: rtl/reg_seq_decode.sv
// reg_seq_decode: combinational decode for the sequencer.
//  - nxt_op/nxt_fire -> nxt_strb_c : strobe vector to be registered for the next cycle
//  - op/strb/data/reg_q/alu_f -> ir_c, il_c, reg_in_c : serial fill bits and
//    parallel input for the strobes currently presented to the register
module reg_seq_decode
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [OP_W-1:0]   nxt_op,
  input  logic              nxt_fire,
  output logic [STB_W-1:0]  nxt_strb_c,
  input  logic [OP_W-1:0]   op,
  input  logic [STB_W-1:0]  strb,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] reg_q,
  input  logic [DATA_W-1:0] alu_f,
  output logic              ir_c,
  output logic              il_c,
  output logic [DATA_W-1:0] reg_in_c
);

  // Opcode -> single strobe; NOP and illegal opcodes map to no strobe
  always_comb begin
    nxt_strb_c = '0;
    if (nxt_fire) begin
      case (nxt_op)
        OP_CLR:         nxt_strb_c[STB_CL]  = 1'b1;
        OP_LD, OP_ALU:  nxt_strb_c[STB_LD]  = 1'b1;
        OP_INC:         nxt_strb_c[STB_INC] = 1'b1;
        OP_DEC:         nxt_strb_c[STB_DEC] = 1'b1;
        OP_SHR, OP_ROR: nxt_strb_c[STB_SR]  = 1'b1;
        OP_SHL, OP_ROL: nxt_strb_c[STB_SL]  = 1'b1;
        default:        nxt_strb_c = '0;
      endcase
    end
  end

  // Rotates feed the register's own end bit back; shifts use the latched fill bit
  always_comb begin
    ir_c     = 1'b0;
    il_c     = 1'b0;
    reg_in_c = '0;
    if (strb[STB_SR]) ir_c = (op == OP_ROR) ? reg_q[0] : data[0];
    if (strb[STB_SL]) il_c = (op == OP_ROL) ? reg_q[DATA_W-1] : data[0];
    if (strb[STB_LD]) reg_in_c = (op == OP_ALU) ? alu_f : data;
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: command-driven controller for the shift/count register and ALU.
// Accepts one command per valid/ready handshake and expands it into
// cycle-accurate register strobes, ALU opcode and operand.
// Ports:
//  clk, rst_n                       clock, async active-low reset
//  abort                            (only with REG_SEQ_ABORT_EN) cancel running command
//  cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//  cmd_op, cmd_cnt, cmd_data        opcode, repeat count / ALU oc, data / fill bit
//  reg_q, alu_f                     register output and ALU result feedback
//  cl, ld, inc, dec, sr, ir, sl, il register control pins
//  reg_in, alu_oc, alu_b            register parallel input, ALU opcode and b operand
//  done, err                        completion pulse, illegal-opcode pulse
// Configuration: define REG_SEQ_ABORT_EN to add the abort input.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef REG_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_cnt,
  input  logic [DATA_W-1:0]  cmd_data,
  input  logic [DATA_W-1:0]  reg_q,
  input  logic [DATA_W-1:0]  alu_f,
  output logic               cl,
  output logic               ld,
  output logic               inc,
  output logic               dec,
  output logic               sr,
  output logic               ir,
  output logic               sl,
  output logic               il,
  output logic [DATA_W-1:0]  reg_in,
  output logic [2:0]         alu_oc,
  output logic [DATA_W-1:0]  alu_b,
  output logic               done,
  output logic               err
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STB_W-1:0]    strb_q, strb_d, strb_out;
  logic                fire_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic [2:0]          alu_oc_q, alu_oc_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                abort_exec, abort_idle;
  logic                accept;

`ifdef REG_SEQ_ABORT_EN
  assign abort_exec = abort && (state_q == ST_EXEC);
  assign abort_idle = abort && (state_q == ST_IDLE);
`else
  assign abort_exec = 1'b0;
  assign abort_idle = 1'b0;
`endif

  assign cmd_ready = ready_q && !abort_idle;
  assign accept    = cmd_valid && cmd_ready;

  // State, latched command, down-counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      alu_oc_q <= '0;
      alu_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      alu_oc_q <= alu_oc_d;
      alu_b_q  <= alu_b_d;
    end
  end

  // Next state and next-cycle output values; cnt_q holds the strobe cycles
  // remaining including the current one
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fire_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ready_d  = 1'b0;
    alu_oc_d = '0;
    alu_b_d  = '0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          op_d    = cmd_op;
          cnt_d   = cmd_cnt;
          data_d  = cmd_data;
          if (is_repeat(cmd_op) && (cmd_cnt != '0)) begin
            state_d = ST_EXEC;
            fire_d  = 1'b1;
            done_d  = (cmd_cnt == COUNT_W'(1));
          end else begin
            state_d = ST_FIN;
            fire_d  = !is_repeat(cmd_op);
            done_d  = 1'b1;
            err_d   = is_illegal(cmd_op);
          end
          if (cmd_op == OP_ALU) begin
            alu_oc_d = cmd_cnt[2:0];
            alu_b_d  = cmd_data;
          end
        end
      end
      ST_EXEC: begin
        if (abort_exec || (cnt_q == COUNT_W'(1))) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - COUNT_W'(1);
          fire_d = 1'b1;
          done_d = (cnt_q == COUNT_W'(2));
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // An abort blanks the strobes and done of the cycle it arrives in
  assign strb_out = abort_exec ? '0 : strb_q;

  reg_seq_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .nxt_op     (op_d),
    .nxt_fire   (fire_d),
    .nxt_strb_c (strb_d),
    .op         (op_q),
    .strb       (strb_out),
    .data       (data_q),
    .reg_q      (reg_q),
    .alu_f      (alu_f),
    .ir_c       (ir),
    .il_c       (il),
    .reg_in_c   (reg_in)
  );

  assign cl     = strb_out[STB_CL];
  assign ld     = strb_out[STB_LD];
  assign inc    = strb_out[STB_INC];
  assign dec    = strb_out[STB_DEC];
  assign sr     = strb_out[STB_SR];
  assign sl     = strb_out[STB_SL];
  assign done   = done_q && !abort_exec;
  assign err    = err_q;
  assign alu_oc = alu_oc_q;
  assign alu_b  = alu_b_q;

endmodule
